block_check_scheduler: RTL

Session scheduler that shares one BlockChecker-style begin/end checker datapath between N_REQ character-stream requesters. It grants the checker to one requester at a time in round-robin order and clears the checker before each session. It forwards the requester's characters under a valid/ready handshake, then samples the checker verdict and returns it to that requester. It sits between the requester front-ends and the single checker instance, which is clocked only on cycles where chk_en=1.

---
 rtl/blksched_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/block_check_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/blksched_pkg.sv
// Shared definitions for the block_check_scheduler slice: FSM state
// encoding, ASCII constants used by benches, default parameters and a
// pointer-width helper.
package blksched_pkg;

    localparam int N_REQ_DEF   = 2;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CLR    = ST_CLR,
        STREAM = ST_STREAM,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6e;
    localparam logic [7:0] CH_D     = 8'h64;

    // Width of an index into n requesters (at least one bit)
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr,
// searching circularly. Output is one-hot, or zero when req is empty.
module rr_arbiter
    import blksched_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Circular priority search starting at ptr
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_check_scheduler.sv
// Shares one begin/end checker between N_REQ character-stream requesters.
// Round-robin session grant, checker clear, character forwarding under
// valid/ready, verdict sampling and return to the owner.
// Optional feature macro: BLKSCHED_TIMEOUT_EN (idle-stream abort with err).
module block_check_scheduler
    import blksched_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   ch_data,
    input  logic [N_REQ-1:0]     ch_valid,
    input  logic [N_REQ-1:0]     ch_last,
    output logic [N_REQ-1:0]     ch_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     pass,
    output logic [N_REQ-1:0]     err,
    output logic [7:0]           chk_data,
    output logic                 chk_en,
    output logic                 chk_rst,
    input  logic                 chk_result
);

    localparam int PW = ptr_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("block_check_scheduler: unsupported N_REQ/TIMEOUT_CYCLES");
    end

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     g_idx;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     nxt_ptr;
    logic [N_REQ-1:0]  arb_gnt;
    logic              hs;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    // One-hot arbiter result to owner index
    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N_REQ; k++)
            if (arb_gnt[k]) sel_idx = PW'(k);
    end

    assign nxt_ptr = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign hs      = (state == STREAM) && ch_valid[g_idx];

    // Characters pass straight through; nothing is injected while the owner idles
    assign chk_en   = hs;
    assign chk_data = hs ? ch_data[g_idx*8 +: 8] : 8'h00;
    assign chk_rst  = reset | (state == CLR);

    // Only the owner sees ready, and only while streaming
    always_comb begin
        ch_ready = '0;
        if (state == STREAM) ch_ready[g_idx] = 1'b1;
    end

`ifdef BLKSCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`else
    assign err = '0;
`endif

    // Session FSM with registered grant/done/pass (and err when enabled)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            g_idx  <= '0;
            grant  <= '0;
            done   <= '0;
            pass   <= '0;
`ifdef BLKSCHED_TIMEOUT_EN
            err    <= '0;
            tcnt   <= '0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= arb_gnt;
                        g_idx <= sel_idx;
                        state <= CLR;
                    end
                end
                CLR: begin
`ifdef BLKSCHED_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    if (!req[g_idx]) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                        state  <= IDLE;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!req[g_idx]) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                        state  <= IDLE;
                    end else if (hs) begin
`ifdef BLKSCHED_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (ch_last[g_idx]) state <= SAMPLE;
                    end
`ifdef BLKSCHED_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        pass[g_idx] <= 1'b0;
                        err[g_idx]  <= 1'b1;
                        done[g_idx] <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                SAMPLE: begin
                    pass[g_idx] <= chk_result;
                    done[g_idx] <= 1'b1;
`ifdef BLKSCHED_TIMEOUT_EN
                    err[g_idx]  <= 1'b0;
`endif
                    state <= DONE;
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= nxt_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
